sized_data_memory: RTL and testbench

Parametrised successor to the single-cycle word data memory used in the MEM stage of the MIPS pipeline.
- Adds byte/halfword/word access (sb/sh/sw, lb/lbu/lh/lhu/lw) with sign/zero extension.
- Adds a configurable access latency with a Busy/Ready stall handshake toward the hazard unit.
- Adds misaligned-access detection.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/sized_data_memory_if.sv | 45 ++++
 rtl/dmem_lane_align.sv | 66 ++++++
 rtl/sized_data_memory.sv | 187 ++++++++++++++++++
 tb/tb_sized_data_memory.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and alignment check for sized_data_memory
//
// Purpose : access-size and FSM state encodings, plus the alignment rule
//           used to decide whether a request faults.
// Ports   : none (package).
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Halves need an even address, words need a 4-byte boundary, and the
  // reserved size code never passes.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~offset[0];
      SIZE_WORD: return (offset == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sized_data_memory_if.sv
// rtl/sized_data_memory_if.sv - request/response bundle of the sized data memory
//
// Purpose : groups the MEM-stage request and response signals.
// Signals : Address, WriteData, MemWrite, MemRead, MemSize, MemUnsigned
//           (requester -> memory); ReadData, Busy, Ready, Misaligned
//           (memory -> requester). With DMEM_STATS_EN defined, adds the
//           LoadCount, StoreCount and FaultCount outputs.
// Modports: master (pipeline side), slave (memory side).
interface sized_data_memory_if #(
  parameter int ADDR_W = 32
) ();

  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [1:0]        MemSize;
  logic              MemUnsigned;
  logic [31:0]       ReadData;
  logic              Busy;
  logic              Ready;
  logic              Misaligned;
`ifdef DMEM_STATS_EN
  logic [31:0]       LoadCount;
  logic [31:0]       StoreCount;
  logic [31:0]       FaultCount;
`endif

  modport master (
    output Address, WriteData, MemWrite, MemRead, MemSize, MemUnsigned,
    input  ReadData, Busy, Ready, Misaligned
`ifdef DMEM_STATS_EN
    , input LoadCount, StoreCount, FaultCount
`endif
  );

  modport slave (
    input  Address, WriteData, MemWrite, MemRead, MemSize, MemUnsigned,
    output ReadData, Busy, Ready, Misaligned
`ifdef DMEM_STATS_EN
    , output LoadCount, StoreCount, FaultCount
`endif
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane merge for stores and extract/extend for loads
//
// Purpose : purely combinational lane steering for little-endian 32-bit words.
// Ports   : i_size      access size code
//           i_offset    byte offset within the word (Address[1:0])
//           i_unsigned  1 = zero-extend loads, 0 = sign-extend
//           i_wdata     right-aligned store data
//           i_old_word  current memory word
//           o_be        byte enables of the addressed lane(s)
//           o_merged    old word with the addressed lane(s) replaced
//           o_load      extended load result taken from i_old_word
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_merged,
  output logic [31:0] o_load
);

  logic [31:0] w_lane_data;
  logic [31:0] w_shifted;

  always_comb begin
    o_be        = 4'b1111;
    w_lane_data = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_be        = 4'b0001 << i_offset;
        // Replicating the byte puts it on every lane; o_be picks the one kept.
        w_lane_data = {4{i_wdata[7:0]}};
      end
      SIZE_HALF: begin
        o_be        = i_offset[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be        = 4'b1111;
        w_lane_data = i_wdata;
      end
    endcase
  end

  always_comb begin
    o_merged = i_old_word;
    for (int i = 0; i < 4; i++) begin
      if (o_be[i]) o_merged[8*i +: 8] = w_lane_data[8*i +: 8];
    end
  end

  always_comb begin
    w_shifted = i_old_word >> {i_offset, 3'b000};
    case (i_size)
      SIZE_BYTE: o_load = i_unsigned ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_HALF: o_load = i_unsigned ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default:   o_load = i_old_word;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// rtl/sized_data_memory.sv - byte/half/word data memory with latency and fault pulse
//
// Purpose : MEM-stage data memory. Accepts one aligned request in IDLE,
//           waits LATENCY cycles in WAIT, performs the access on the edge
//           entering DONE and pulses Ready with the extended load data.
//           Misaligned requests pulse Misaligned and leave memory untouched.
// Ports   : Clk  rising-edge clock
//           Rst  synchronous active-high reset (memory contents kept)
//           bus  sized_data_memory_if.slave request/response bundle
// Config  : DMEM_STATS_EN adds saturating load/store/fault counters.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 0
) (
  input logic                 Clk,
  input logic                 Rst,
  sized_data_memory_if.slave  bus
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [31:0] r_mem [DEPTH];

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_off;
  logic [1:0]       r_size;
  logic             r_uns;
  logic [31:0]      r_wdata;
  logic             r_write;
  logic             r_ready;
  logic             r_misaligned;
  logic [31:0]      r_rdata;

  logic             w_req;
  logic             w_aligned;
  logic             w_accept;
  logic             w_in_idle;
  logic             w_enter_done;
  logic [IDX_W-1:0] w_sel_idx;
  logic [1:0]       w_sel_off;
  logic [1:0]       w_sel_size;
  logic             w_sel_uns;
  logic [31:0]      w_sel_wdata;
  logic             w_sel_write;
  logic [31:0]      w_old_word;
  logic [3:0]       w_be;
  logic [31:0]      w_merged;
  logic [31:0]      w_load;

  // Upper address bits wrap modulo DEPTH and are deliberately ignored.
  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^bus.Address[ADDR_W-1:IDX_W+2];
  end

  assign w_req     = bus.MemRead | bus.MemWrite;
  assign w_aligned = is_aligned(bus.MemSize, bus.Address[1:0]);
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle & w_req & w_aligned;

  // With zero latency the access happens on the accepting edge, so the lane
  // logic must see the live request rather than the latched copy.
  assign w_sel_idx   = w_in_idle ? bus.Address[IDX_W+1:2] : r_idx;
  assign w_sel_off   = w_in_idle ? bus.Address[1:0]       : r_off;
  assign w_sel_size  = w_in_idle ? bus.MemSize            : r_size;
  assign w_sel_uns   = w_in_idle ? bus.MemUnsigned        : r_uns;
  assign w_sel_wdata = w_in_idle ? bus.WriteData          : r_wdata;
  assign w_sel_write = w_in_idle ? bus.MemWrite           : r_write;

  assign w_enter_done = (w_accept && (LAT == 4'd0)) ||
                        ((r_state == ST_WAIT) && (r_cnt == 4'd1));

  assign w_old_word = r_mem[w_sel_idx];

  dmem_lane_align u_lane_align (
    .i_size     (w_sel_size),
    .i_offset   (w_sel_off),
    .i_unsigned (w_sel_uns),
    .i_wdata    (w_sel_wdata),
    .i_old_word (w_old_word),
    .o_be       (w_be),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  // Gating on !Rst is what aborts a store still pending in WAIT.
  always_ff @(posedge Clk) begin
    if (!Rst && w_enter_done && w_sel_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_sel_idx][8*i +: 8] <= w_merged[8*i +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_off        <= 2'd0;
      r_size       <= 2'd0;
      r_uns        <= 1'b0;
      r_wdata      <= 32'd0;
      r_write      <= 1'b0;
      r_ready      <= 1'b0;
      r_misaligned <= 1'b0;
      r_rdata      <= 32'd0;
    end else begin
      r_ready      <= 1'b0;
      r_misaligned <= 1'b0;
      r_rdata      <= 32'd0;
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_aligned) begin
            r_misaligned <= 1'b1;
          end else if (w_accept) begin
            r_idx   <= bus.Address[IDX_W+1:2];
            r_off   <= bus.Address[1:0];
            r_size  <= bus.MemSize;
            r_uns   <= bus.MemUnsigned;
            r_wdata <= bus.WriteData;
            r_write <= bus.MemWrite;
            r_cnt   <= LAT;
            if (LAT == 4'd0) begin
              r_state <= ST_DONE;
              r_ready <= 1'b1;
              r_rdata <= w_load;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_rdata <= w_load;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ReadData   = r_rdata;
  assign bus.Ready      = r_ready;
  assign bus.Misaligned = r_misaligned;
  assign bus.Busy       = w_accept | (r_state == ST_WAIT);

`ifdef DMEM_STATS_EN
  logic [31:0] r_load_cnt;
  logic [31:0] r_store_cnt;
  logic [31:0] r_fault_cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_load_cnt  <= 32'd0;
      r_store_cnt <= 32'd0;
      r_fault_cnt <= 32'd0;
    end else begin
      if (r_ready) begin
        if (r_write) begin
          if (r_store_cnt != 32'hFFFF_FFFF) r_store_cnt <= r_store_cnt + 32'd1;
        end else begin
          if (r_load_cnt != 32'hFFFF_FFFF) r_load_cnt <= r_load_cnt + 32'd1;
        end
      end
      if (r_misaligned && (r_fault_cnt != 32'hFFFF_FFFF)) begin
        r_fault_cnt <= r_fault_cnt + 32'd1;
      end
    end
  end

  assign bus.LoadCount  = r_load_cnt;
  assign bus.StoreCount = r_store_cnt;
  assign bus.FaultCount = r_fault_cnt;
`endif

endmodule

// File: tb/tb_sized_data_memory.sv
// tb/tb_sized_data_memory.sv - scoreboard bench for sized_data_memory (LATENCY 0 and 3)
module tb_sized_data_memory;
  import dmem_pkg::*;

  typedef struct {
    bit          fault;
    bit          chk;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst0;
  logic rst3;

  int          d_sel;
  logic        d_rd;
  logic        d_wr;
  logic [1:0]  d_size;
  logic        d_uns;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  int checks = 0;
  int errors = 0;
  int n_load  [2] = '{0, 0};
  int n_store [2] = '{0, 0};
  int n_fault [2] = '{0, 0};

  exp_t q0[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  sized_data_memory_if #(.ADDR_W(32)) b0 ();
  sized_data_memory_if #(.ADDR_W(32)) b3 ();

  assign b0.Address     = d_addr;
  assign b0.WriteData   = d_wdata;
  assign b0.MemSize     = d_size;
  assign b0.MemUnsigned = d_uns;
  assign b0.MemRead     = d_rd & (d_sel == 0);
  assign b0.MemWrite    = d_wr & (d_sel == 0);
  assign b3.Address     = d_addr;
  assign b3.WriteData   = d_wdata;
  assign b3.MemSize     = d_size;
  assign b3.MemUnsigned = d_uns;
  assign b3.MemRead     = d_rd & (d_sel == 1);
  assign b3.MemWrite    = d_wr & (d_sel == 1);

  sized_data_memory #(.DEPTH(16), .ADDR_W(32), .LATENCY(0)) dut0 (
    .Clk (clk),
    .Rst (rst0),
    .bus (b0)
  );

  sized_data_memory #(.DEPTH(16), .ADDR_W(32), .LATENCY(3)) dut3 (
    .Clk (clk),
    .Rst (rst3),
    .bus (b3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? b0.Busy : b3.Busy;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? b0.Ready : b3.Ready;
  endfunction

  function automatic logic get_mis(input int sel);
    return (sel == 0) ? b0.Misaligned : b3.Misaligned;
  endfunction

  task automatic monitor_event(input int sel);
    exp_t        e;
    logic        rdy;
    logic        mis;
    logic [31:0] rd;
    rdy = get_ready(sel);
    mis = get_mis(sel);
    rd  = (sel == 0) ? b0.ReadData : b3.ReadData;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q3.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event dut%0d: ready=%0b misaligned=%0b with nothing outstanding",
               sel, rdy, mis);
    end else begin
      e = (sel == 0) ? q0.pop_front() : q3.pop_front();
      if (e.fault) begin
        check({e.name, "_misaligned"}, 32'(mis), 32'd1);
        check({e.name, "_no_ready"}, 32'(rdy), 32'd0);
        check({e.name, "_fault_rdata"}, rd, 32'd0);
      end else begin
        check({e.name, "_ready"}, 32'(rdy), 32'd1);
        check({e.name, "_no_fault"}, 32'(mis), 32'd0);
        if (e.chk) check({e.name, "_rdata"}, rd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (b0.Ready || b0.Misaligned) monitor_event(0);
    else check("dut0_rdata_idle_zero", b0.ReadData, 32'd0);
  end

  always @(negedge clk) begin
    if (b3.Ready || b3.Misaligned) monitor_event(1);
    else check("dut3_rdata_idle_zero", b3.ReadData, 32'd0);
  end

  // Issue one request, push its expected response, and check timing:
  // completion LATENCY+1 cycles after the request edge with Busy high for
  // LATENCY+1 cycles, or a fault one cycle after with Busy never high.
  task automatic acc(input int sel, input bit rd, input bit wr, input logic [1:0] sz,
                     input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                     input bit fault, input bit chk, input logic [31:0] exp,
                     input string name, input bit scr = 1'b0);
    exp_t e;
    int   cyc;
    int   busy_n;
    int   lat;
    lat     = (sel == 0) ? 0 : 3;
    e.fault = fault;
    e.chk   = chk;
    e.data  = exp;
    e.name  = name;
    @(negedge clk);
    if (sel == 0) q0.push_back(e);
    else q3.push_back(e);
    if (fault) n_fault[sel]++;
    else if (wr) n_store[sel]++;
    else n_load[sel]++;
    d_sel = sel; d_rd = rd; d_wr = wr; d_size = sz; d_uns = uns; d_addr = addr; d_wdata = wd;
    busy_n = 0;
    #1;
    if (get_busy(sel)) busy_n++;
    @(posedge clk);
    @(negedge clk);
    cyc  = 1;
    d_rd = 1'b0;
    d_wr = 1'b0;
    while (!get_ready(sel) && !get_mis(sel) && cyc < 20) begin
      if (get_busy(sel)) busy_n++;
      if (scr) begin
        d_rd   = 1'b1;
        d_addr = d_addr + 32'd4;
        d_size = SIZE_BYTE;
      end
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_busy"}, 32'(get_busy(sel)), 32'd0);
    d_rd = 1'b0;
    check({name, "_latency"}, 32'(cyc), fault ? 32'd1 : 32'(lat + 1));
    check({name, "_busy_cycles"}, 32'(busy_n), fault ? 32'd0 : 32'(lat + 1));
  endtask

  task automatic abort_store();
    @(negedge clk);
    d_sel = 1; d_rd = 1'b0; d_wr = 1'b1; d_size = SIZE_WORD; d_uns = 1'b0;
    d_addr = 32'd8; d_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    d_wr = 1'b0;
    check("abort_busy_in_wait", 32'(b3.Busy), 32'd1);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    n_load[1] = 0; n_store[1] = 0; n_fault[1] = 0;
    check("abort_idle_after_reset", 32'(b3.Busy), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_ready", 32'(b3.Ready), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1; rst3 = 1'b1;
    d_sel = 0; d_rd = 1'b0; d_wr = 1'b0; d_size = SIZE_WORD; d_uns = 1'b0;
    d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(b0.Ready), 32'd0);
    check("reset_misaligned", 32'(b0.Misaligned), 32'd0);
    check("reset_busy", 32'(b0.Busy), 32'd0);
    check("reset_rdata", b3.ReadData, 32'd0);

    // LATENCY=0 instance
    acc(0, 0, 1, SIZE_WORD, 0, 32'd0,  32'h1122_3344, 0, 0, 32'd0,          "sw0");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd0,  32'd0,         0, 1, 32'h1122_3344,  "lw0");
    acc(0, 0, 1, SIZE_BYTE, 0, 32'd1,  32'h1234_56AA, 0, 0, 32'd0,          "sb1");
    acc(0, 1, 0, SIZE_BYTE, 0, 32'd1,  32'd0,         0, 1, 32'hFFFF_FFAA,  "lb1");
    acc(0, 1, 0, SIZE_BYTE, 1, 32'd1,  32'd0,         0, 1, 32'h0000_00AA,  "lbu1");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd0,  32'd0,         0, 1, 32'h1122_AA44,  "lw0_after_sb");
    acc(0, 0, 1, SIZE_HALF, 0, 32'd2,  32'hCAFE_8001, 0, 0, 32'd0,          "sh2");
    acc(0, 1, 0, SIZE_HALF, 0, 32'd2,  32'd0,         0, 1, 32'hFFFF_8001,  "lh2");
    acc(0, 1, 0, SIZE_HALF, 1, 32'd2,  32'd0,         0, 1, 32'h0000_8001,  "lhu2");
    acc(0, 1, 0, SIZE_HALF, 0, 32'd3,  32'd0,         1, 0, 32'd0,          "lh3_fault");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd0,  32'd0,         0, 1, 32'h8001_AA44,  "lw0_after_fault");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd64, 32'd0,         0, 1, 32'h8001_AA44,  "lw_alias");
    acc(0, 1, 0, SIZE_ILLEGAL, 0, 32'd0, 32'd0,       1, 0, 32'd0,          "size11_fault");
    acc(0, 0, 1, SIZE_WORD, 0, 32'd2,  32'hFFFF_FFFF, 1, 0, 32'd0,          "sw2_fault");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd0,  32'd0,         0, 1, 32'h8001_AA44,  "lw0_no_store");
    acc(0, 1, 1, SIZE_BYTE, 0, 32'd3,  32'h0000_007F, 0, 1, 32'hFFFF_FF80,  "rdwr3");
    acc(0, 1, 0, SIZE_WORD, 0, 32'd0,  32'd0,         0, 1, 32'h7F01_AA44,  "lw0_after_rdwr");
    acc(0, 1, 0, SIZE_BYTE, 0, 32'd0,  32'd0,         0, 1, 32'h0000_0044,  "lb0_pos");
    acc(0, 1, 0, SIZE_HALF, 0, 32'd0,  32'd0,         0, 1, 32'hFFFF_AA44,  "lh0");
    acc(0, 1, 0, SIZE_WORD, 1, 32'd0,  32'd0,         0, 1, 32'h7F01_AA44,  "lw0_unsigned");

    // LATENCY=3 instance
    acc(1, 0, 1, SIZE_WORD, 0, 32'd8,  32'h1234_5678, 0, 0, 32'd0,          "sw8_lat3");
    acc(1, 1, 0, SIZE_WORD, 0, 32'd8,  32'd0,         0, 1, 32'h1234_5678,  "lw8_lat3_scramble", 1'b1);
    abort_store();
    acc(1, 1, 0, SIZE_WORD, 0, 32'd8,  32'd0,         0, 1, 32'h1234_5678,  "lw8_after_abort");
    acc(1, 1, 0, SIZE_BYTE, 0, 32'd9,  32'd0,         0, 1, 32'h0000_0056,  "lb9_lat3");
    acc(1, 1, 0, SIZE_HALF, 0, 32'd9,  32'd0,         1, 0, 32'd0,          "lh9_fault_lat3");
    acc(1, 1, 0, SIZE_HALF, 0, 32'd10, 32'd0,         0, 1, 32'h0000_1234,  "lh10_lat3");

    repeat (4) @(negedge clk);
    check("dut0_queue_drained", 32'(q0.size()), 32'd0);
    check("dut3_queue_drained", 32'(q3.size()), 32'd0);
`ifdef DMEM_STATS_EN
    check("dut0_load_count",  b0.LoadCount,  32'(n_load[0]));
    check("dut0_store_count", b0.StoreCount, 32'(n_store[0]));
    check("dut0_fault_count", b0.FaultCount, 32'(n_fault[0]));
    check("dut3_load_count",  b3.LoadCount,  32'(n_load[1]));
    check("dut3_store_count", b3.StoreCount, 32'(n_store[1]));
    check("dut3_fault_count", b3.FaultCount, 32'(n_fault[1]));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
